// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the i2c_init_seq configuration-table sequencer.
// The DELAY state exists only when I2C_SEQ_DELAY_EN is defined.
package i2c_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_FETCH = 4'd1,
      ST_CHECK = 4'd2,
      ST_REQ   = 4'd3,
      ST_ACK   = 4'd4,
      ST_NEXT  = 4'd5,
      ST_DONE  = 4'd6,
      ST_ERR   = 4'd7
`ifdef I2C_SEQ_DELAY_EN
      ,
      ST_DELAY = 4'd8
`endif
   } seq_state_t;

   localparam logic [31:0] SEQ_END_WORD  = 32'hFFFF_FFFF;
   localparam logic [7:0]  SEQ_DELAY_TAG = 8'hFE;

   function automatic logic is_busy_state(input seq_state_t s);
      return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR));
   endfunction

endpackage

// File: rtl/i2c_init_seq_sync2.sv
// Two-flop synchroniser bringing the slow configure_rdy flag into clk_24m.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic q_r;

   // synchroniser chain
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b0;
         q_r    <= 1'b0;
      end else begin
         meta_r <= d;
         q_r    <= meta_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/i2c_init_seq.sv
// Walks a 32-bit configuration ROM and hands each word to the IIC configure block.
// Optional inline millisecond delays are enabled with the I2C_SEQ_DELAY_EN macro.
module i2c_init_seq
   import i2c_seq_pkg::*;
#(
   parameter int TABLE_DEPTH = 64,
   parameter int TIMEOUT_CYC = 240000,
   parameter int MS_CYC      = 24000
) (
   input  logic                           clk_24m,
   input  logic                           reset,
   input  logic                           go,
   output logic [$clog2(TABLE_DEPTH)-1:0] tbl_addr,
   input  logic [31:0]                    tbl_data,
   output logic                           configure_en,
   output logic [31:0]                    configure_data,
   input  logic                           configure_rdy,
   output logic                           busy,
   output logic                           done,
   output logic                           error,
   output logic [$clog2(TABLE_DEPTH)-1:0] err_idx
);

   localparam int AW = $clog2(TABLE_DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(TABLE_DEPTH - 1);
   localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT_CYC - 1);

   seq_state_t    state_r, state_s;
   logic [AW-1:0] index_r, index_s;
   logic [31:0]   cnt_r, cnt_s;
   logic          en_r, en_s;
   logic [31:0]   data_r, data_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;
   logic          error_r, error_s;
   logic [AW-1:0] err_idx_r, err_idx_s;
   logic          rdy_s;

`ifdef I2C_SEQ_DELAY_EN
   function automatic logic [31:0] delay_cycles(input logic [15:0] ms);
      return 32'(ms) * 32'(MS_CYC);
   endfunction
`endif

   sync2 u_rdy_sync (
      .clk   (clk_24m),
      .reset (reset),
      .d     (configure_rdy),
      .q     (rdy_s)
   );

   // next-state and next-output logic; cnt_r is shared by timeout and delay
   always_comb begin
      state_s   = state_r;
      index_s   = index_r;
      cnt_s     = cnt_r;
      en_s      = en_r;
      data_s    = data_r;
      done_s    = done_r;
      error_s   = error_r;
      err_idx_s = err_idx_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (go) begin
               done_s  = 1'b0;
               error_s = 1'b0;
               index_s = '0;
               state_s = ST_FETCH;
            end else begin
               state_s = state_r;
            end
         end
         ST_FETCH: begin
            state_s = ST_CHECK;
         end
         ST_CHECK: begin
            data_s = tbl_data;
            cnt_s  = 32'd0;
            if (tbl_data == SEQ_END_WORD) begin
               done_s  = 1'b1;
               state_s = ST_DONE;
`ifdef I2C_SEQ_DELAY_EN
            end else if (tbl_data[31:24] == SEQ_DELAY_TAG) begin
               cnt_s   = delay_cycles(tbl_data[15:0]);
               state_s = ST_DELAY;
`endif
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_REQ: begin
            // rdy falling while en is high means the configure block took the word
            if (en_r && !rdy_s) begin
               en_s    = 1'b0;
               cnt_s   = 32'd0;
               state_s = ST_ACK;
            end else if (cnt_r == TMO_LAST) begin
               en_s      = 1'b0;
               error_s   = 1'b1;
               err_idx_s = index_r;
               state_s   = ST_ERR;
            end else begin
               en_s  = en_r | rdy_s;
               cnt_s = cnt_r + 32'd1;
            end
         end
         ST_ACK: begin
            if (rdy_s) begin
               state_s = ST_NEXT;
            end else if (cnt_r == TMO_LAST) begin
               error_s   = 1'b1;
               err_idx_s = index_r;
               state_s   = ST_ERR;
            end else begin
               cnt_s = cnt_r + 32'd1;
            end
         end
`ifdef I2C_SEQ_DELAY_EN
         ST_DELAY: begin
            if (cnt_r == 32'd0) begin
               state_s = ST_NEXT;
            end else begin
               cnt_s = cnt_r - 32'd1;
            end
         end
`endif
         ST_NEXT: begin
            if (index_r == LAST_IDX) begin
               done_s  = 1'b1;
               state_s = ST_DONE;
            end else begin
               index_s = index_r + AW'(1);
               state_s = ST_FETCH;
            end
         end
         default: begin
            en_s    = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
      busy_s = is_busy_state(state_s);
   end

   // state and output registers
   always_ff @(posedge clk_24m) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         index_r   <= '0;
         cnt_r     <= 32'd0;
         en_r      <= 1'b0;
         data_r    <= 32'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         error_r   <= 1'b0;
         err_idx_r <= '0;
      end else begin
         state_r   <= state_s;
         index_r   <= index_s;
         cnt_r     <= cnt_s;
         en_r      <= en_s;
         data_r    <= data_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         error_r   <= error_s;
         err_idx_r <= err_idx_s;
      end
   end

   assign tbl_addr       = index_r;
   assign configure_en   = en_r;
   assign configure_data = data_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign error          = error_r;
   assign err_idx        = err_idx_r;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Scoreboard bench for i2c_init_seq: a behavioural configure block accepts words and
// checks them against the expected queue filled when each table is loaded.
module tb_i2c_init_seq;

   localparam int DEPTH = 4;
   localparam int TMO   = 1000;
   localparam int MS    = 100;
   localparam int FALL  = 30;
   localparam int RISE  = 500;
   localparam logic [31:0] END_W = 32'hFFFF_FFFF;

   logic        clk_24m = 1'b0;
   logic        reset;
   logic        go;
   logic [1:0]  tbl_addr;
   logic [31:0] tbl_data;
   logic        configure_en;
   logic [31:0] configure_data;
   logic        configure_rdy = 1'b1;
   logic        busy, done, error;
   logic [1:0]  err_idx;

   logic [31:0] rom [0:3];
   logic [31:0] sb [$];
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int xfer_cnt = 0;
   int rise_cyc = 0;
   int gap_last = 0;
   int m_state  = 0;
   int m_cnt    = 0;
   bit stuck    = 1'b0;

   i2c_init_seq #(.TABLE_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .MS_CYC(MS)) dut (
      .clk_24m        (clk_24m),
      .reset          (reset),
      .go             (go),
      .tbl_addr       (tbl_addr),
      .tbl_data       (tbl_data),
      .configure_en   (configure_en),
      .configure_data (configure_data),
      .configure_rdy  (configure_rdy),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .err_idx        (err_idx)
   );

   always #5 clk_24m = ~clk_24m;

   always @(posedge clk_24m) tbl_data <= rom[tbl_addr];
   always @(posedge clk_24m) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // configure-block model: rdy falls FALL cycles after en, rises RISE cycles later
   always @(negedge clk_24m) begin
      case (m_state)
         0: if (configure_en && !stuck) begin
               m_cnt    <= 1;
               m_state  <= 1;
               gap_last <= cyc - rise_cyc;
            end
         1: if (m_cnt == FALL) begin
               configure_rdy <= 1'b0;
               m_state  <= 2;
               m_cnt    <= 1;
               xfer_cnt <= xfer_cnt + 1;
               if (sb.size() == 0) check_eq("unexpected_xfer", configure_data, 32'h0);
               else check_eq("xfer_data", configure_data, sb.pop_front());
            end else m_cnt <= m_cnt + 1;
         2: if (m_cnt == RISE) begin
               configure_rdy <= 1'b1;
               m_state  <= 0;
               rise_cyc <= cyc;
            end else m_cnt <= m_cnt + 1;
         default: m_state <= 0;
      endcase
   end

   task automatic load(input logic [31:0] w0, w1, w2, w3);
      rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
   endtask

   task automatic pulse_go();
      @(negedge clk_24m) go = 1'b1;
      @(negedge clk_24m) go = 1'b0;
   endtask

   task automatic wait_end(input int budget, output int n);
      n = 0;
      while (!(done || error) && n < budget) begin
         @(negedge clk_24m);
         n++;
      end
      check_eq("wait_end", 32'(done | error), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_en"},      32'(configure_en), 32'd0);
      check_eq({tag, "_data"},    configure_data, 32'd0);
      check_eq({tag, "_addr"},    32'(tbl_addr), 32'd0);
      check_eq({tag, "_busy"},    32'(busy), 32'd0);
      check_eq({tag, "_done"},    32'(done), 32'd0);
      check_eq({tag, "_error"},   32'(error), 32'd0);
      check_eq({tag, "_err_idx"}, 32'(err_idx), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int base;
      reset = 1'b1;
      go    = 1'b0;
      load(END_W, END_W, END_W, END_W);
      repeat (3) @(negedge clk_24m);
      check_reset_vals("rst");
      reset = 1'b0;
      repeat (5) @(negedge clk_24m);

      // two writes then end marker
      load(32'h7800_0111, 32'h7800_0222, END_W, END_W);
      sb.push_back(32'h7800_0111); sb.push_back(32'h7800_0222);
      base = xfer_cnt;
      pulse_go();
      check_eq("go_busy", 32'(busy), 32'd1);
      check_eq("go_addr", 32'(tbl_addr), 32'd0);
      wait_end(5000, n);
      check_eq("t1_done", 32'(done), 32'd1);
      check_eq("t1_busy", 32'(busy), 32'd0);
      check_eq("t1_error", 32'(error), 32'd0);
      check_eq("t1_xfers", 32'(xfer_cnt - base), 32'd2);
      check_eq("t1_sb_left", 32'(sb.size()), 32'd0);

      // full table without end marker, go pulsed while busy
      load(32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004);
      sb.push_back(32'h1111_0001); sb.push_back(32'h2222_0002);
      sb.push_back(32'h3333_0003); sb.push_back(32'h4444_0004);
      base = xfer_cnt;
      pulse_go();
      repeat (200) @(negedge clk_24m);
      pulse_go();
      wait_end(8000, n);
      check_eq("t2_done", 32'(done), 32'd1);
      check_eq("t2_xfers", 32'(xfer_cnt - base), 32'd4);
      check_eq("t2_sb_left", 32'(sb.size()), 32'd0);
      check_eq("t2_last_addr", 32'(tbl_addr), 32'd3);

      // rdy never falls: timeout in REQ of entry 0
      stuck = 1'b1;
      load(32'h7800_0333, END_W, END_W, END_W);
      pulse_go();
      wait_end(2000, n);
      check_eq("tmo_error", 32'(error), 32'd1);
      check_eq("tmo_done", 32'(done), 32'd0);
      check_eq("tmo_err_idx", 32'(err_idx), 32'd0);
      check_eq("tmo_en", 32'(configure_en), 32'd0);
      check_eq("tmo_busy", 32'(busy), 32'd0);
      check_eq("tmo_window", 32'(n >= TMO && n <= TMO + 10), 32'd1);

      // go after ERR clears error and reruns
      stuck = 1'b0;
      sb.push_back(32'h7800_0333);
      pulse_go();
      check_eq("rerun_err_clr", 32'(error), 32'd0);
      wait_end(5000, n);
      check_eq("rerun_done", 32'(done), 32'd1);
      check_eq("rerun_error", 32'(error), 32'd0);
      check_eq("rerun_sb_left", 32'(sb.size()), 32'd0);

      // delay word between two writes
      load(32'h7800_0AAA, 32'hFE00_0003, 32'h7800_0BBB, END_W);
      sb.push_back(32'h7800_0AAA);
`ifndef I2C_SEQ_DELAY_EN
      sb.push_back(32'hFE00_0003);
`endif
      sb.push_back(32'h7800_0BBB);
      base = xfer_cnt;
      pulse_go();
      wait_end(8000, n);
      check_eq("dly_done", 32'(done), 32'd1);
      check_eq("dly_sb_left", 32'(sb.size()), 32'd0);
`ifdef I2C_SEQ_DELAY_EN
      check_eq("dly_xfers", 32'(xfer_cnt - base), 32'd2);
      check_eq("dly_gap", 32'(gap_last >= 3 * MS && gap_last <= 3 * MS + 40), 32'd1);
`else
      check_eq("dly_xfers", 32'(xfer_cnt - base), 32'd3);
`endif

      // reset while ACK of entry 1, then restart from index 0
      load(32'h7800_0C01, 32'h7800_0C02, 32'h7800_0C03, END_W);
      sb.push_back(32'h7800_0C01); sb.push_back(32'h7800_0C02); sb.push_back(32'h7800_0C03);
      base = xfer_cnt;
      pulse_go();
      n = 0;
      while (xfer_cnt != base + 2 && n < 3000) begin
         @(negedge clk_24m);
         n++;
      end
      check_eq("rst_reach_ack", 32'(xfer_cnt - base), 32'd2);
      repeat (10) @(negedge clk_24m);
      reset = 1'b1;
      @(negedge clk_24m);
      check_reset_vals("mid_rst");
      reset = 1'b0;
      sb.delete();
      sb.push_back(32'h7800_0C01); sb.push_back(32'h7800_0C02); sb.push_back(32'h7800_0C03);
      base = xfer_cnt;
      pulse_go();
      check_eq("restart_addr", 32'(tbl_addr), 32'd0);
      check_eq("restart_busy", 32'(busy), 32'd1);
      wait_end(8000, n);
      check_eq("restart_done", 32'(done), 32'd1);
      check_eq("restart_xfers", 32'(xfer_cnt - base), 32'd3);
      check_eq("restart_sb_left", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
